cache_set_assoc_multiword: RTL and testbench

//  Parametrised N-way set-associative, multiword-block instruction cache. It generalises the direct-mapped multiword cache.

---
 rtl/cache_set_assoc_multiword.sv | 253 +++++++++++++++++++++++++
 tb/tb_cache_set_assoc_multiword.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache_set_assoc_multiword.sv
// N-way set-associative multiword instruction cache with its own refill FSM, true-LRU and saturating counters.
// Optional feature: define CACHE_FLUSH_EN to add the FLUSH input (invalidate all lines).
module cache_set_assoc_multiword #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 2,
    parameter int SETS            = 4,
    parameter int WAYS            = 2,
    parameter int CNT_W           = 20
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              REQ,
`ifdef CACHE_FLUSH_EN
    input  logic                              FLUSH,
`endif
    input  logic [ADDR_W-1:0]                 PC,
    output logic                              HIT,
    output logic                              DATA_VALID,
    output logic [DATA_W-1:0]                 Data_Cache,
    output logic                              STALL,
    output logic                              MM_REQ,
    output logic [ADDR_W-1:0]                 MM_ADDR,
    input  logic                              MM_VALID,
    input  logic [DATA_W*WORDS_PER_BLOCK-1:0] MM_DATA,
    output logic [CNT_W-1:0]                  CNT_HIT,
    output logic [CNT_W-1:0]                  CNT_MISS
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_B = $clog2(SETS);
    localparam int IDX_W = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_B;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W = DATA_W * WORDS_PER_BLOCK;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << (2 + OFF_W);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MISS = 2'd1, S_FILL = 2'd2} state_t;
    typedef logic [WAYS-1:0][AGE_W-1:0] age_row_t;
    typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;
    typedef logic [WAYS-1:0][BLK_W-1:0] blk_row_t;

    state_t            state_q, state_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    tag_row_t          tag_q   [SETS];
    tag_row_t          tag_d   [SETS];
    blk_row_t          blk_q   [SETS];
    blk_row_t          blk_d   [SETS];
    age_row_t          age_q   [SETS];
    age_row_t          age_d   [SETS];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_hit_q, cnt_hit_d, cnt_miss_q, cnt_miss_d;
    logic              flush_pend_q, flush_pend_d;

    logic [ADDR_W-1:0] lk_addr_s, sh_idx_s, sh_tag_s, sh_off_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [OFF_W-1:0]  off_s;
    logic              hit_s, inv_s, flush_in_s, flush_now_s;
    logic [AGE_W-1:0]  hit_way_s, vict_way_s;
    logic [DATA_W-1:0] hit_word_s;

    // Ways younger than the touched way age by one; the touched way becomes MRU.
    function automatic age_row_t lru_touch(input age_row_t row, input logic [AGE_W-1:0] way);
        age_row_t r;
        r = row;
        for (int w = 0; w < WAYS; w++) begin
            if (row[w] < row[way]) r[w] = row[w] + AGE_W'(1);
        end
        r[way] = {AGE_W{1'b0}};
        return r;
    endfunction

    function automatic age_row_t lru_init();
        age_row_t r;
        for (int w = 0; w < WAYS; w++) r[w] = AGE_W'(w);
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) return c;
        else    return c + CNT_W'(1);
    endfunction

`ifdef CACHE_FLUSH_EN
    assign flush_in_s = FLUSH;
`else
    assign flush_in_s = 1'b0;
`endif
    assign flush_now_s = flush_in_s | flush_pend_q;

    // In IDLE the live PC is looked up; during refill the latched miss address is used.
    assign lk_addr_s = (state_q == S_IDLE) ? PC : pc_q;
    assign sh_off_s  = lk_addr_s >> 2;
    assign sh_idx_s  = lk_addr_s >> (2 + OFF_W);
    assign sh_tag_s  = lk_addr_s >> (2 + OFF_W + IDX_B);
    assign off_s     = sh_off_s[OFF_W-1:0];
    assign idx_s     = (SETS > 1) ? sh_idx_s[IDX_W-1:0] : {IDX_W{1'b0}};
    assign tag_s     = sh_tag_s[TAG_W-1:0];

    // Tag compare across ways plus victim choice: lowest invalid way, else the oldest.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = {AGE_W{1'b0}};
        inv_s      = 1'b0;
        vict_way_s = {AGE_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = AGE_W'(w);
            end else begin
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_s][w]) begin
                inv_s      = 1'b1;
                vict_way_s = AGE_W'(w);
            end else begin
            end
        end
        if (!inv_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx_s][w] == AGE_W'(WAYS - 1)) vict_way_s = AGE_W'(w);
                else vict_way_s = vict_way_s;
            end
        end else begin
        end
        hit_word_s = blk_q[idx_s][hit_way_s][off_s*DATA_W +: DATA_W];
    end

    // Next-state logic for the refill FSM, line arrays, LRU and counters.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        blk_d        = blk_q;
        age_d        = age_q;
        pc_d         = pc_q;
        word_d       = word_q;
        cnt_hit_d    = cnt_hit_q;
        cnt_miss_d   = cnt_miss_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (flush_now_s) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_d[s] = {WAYS{1'b0}};
                        age_d[s]   = lru_init();
                    end
                    flush_pend_d = 1'b0;
                end else if (REQ) begin
                    if (hit_s) begin
                        cnt_hit_d    = sat_inc(cnt_hit_q);
                        age_d[idx_s] = lru_touch(age_q[idx_s], hit_way_s);
                    end else begin
                        pc_d       = PC;
                        cnt_miss_d = sat_inc(cnt_miss_q);
                        state_d    = S_MISS;
                    end
                end else begin
                end
            end
            S_MISS: begin
                if (flush_in_s) flush_pend_d = 1'b1;
                else flush_pend_d = flush_pend_q;
                if (MM_VALID) begin
                    valid_d[idx_s][vict_way_s] = 1'b1;
                    tag_d[idx_s][vict_way_s]   = tag_s;
                    blk_d[idx_s][vict_way_s]   = MM_DATA;
                    age_d[idx_s]               = lru_touch(age_q[idx_s], vict_way_s);
                    word_d                     = MM_DATA[off_s*DATA_W +: DATA_W];
                    state_d                    = S_FILL;
                end else begin
                end
            end
            S_FILL: begin
                if (flush_in_s) flush_pend_d = 1'b1;
                else flush_pend_d = flush_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset invalidates every line and restores the LRU order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                tag_q[s]   <= {(WAYS*TAG_W){1'b0}};
                blk_q[s]   <= {(WAYS*BLK_W){1'b0}};
                age_q[s]   <= lru_init();
            end
            pc_q         <= {ADDR_W{1'b0}};
            word_q       <= {DATA_W{1'b0}};
            cnt_hit_q    <= {CNT_W{1'b0}};
            cnt_miss_q   <= {CNT_W{1'b0}};
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            blk_q        <= blk_d;
            age_q        <= age_d;
            pc_q         <= pc_d;
            word_q       <= word_d;
            cnt_hit_q    <= cnt_hit_d;
            cnt_miss_q   <= cnt_miss_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Fetch-side outputs; gated by RESET so a mid-refill reset drops STALL/MM_REQ at once.
    always_comb begin
        HIT        = 1'b0;
        DATA_VALID = 1'b0;
        Data_Cache = {DATA_W{1'b0}};
        STALL      = 1'b0;
        MM_REQ     = 1'b0;
        MM_ADDR    = {ADDR_W{1'b0}};
        if (RESET) begin
            case (state_q)
                S_IDLE: begin
                    if (REQ && !flush_now_s) begin
                        HIT        = hit_s;
                        DATA_VALID = hit_s;
                        Data_Cache = hit_s ? hit_word_s : {DATA_W{1'b0}};
                        STALL      = !hit_s;
                    end else begin
                    end
                end
                S_MISS: begin
                    STALL   = 1'b1;
                    MM_REQ  = 1'b1;
                    MM_ADDR = pc_q & ALIGN_MASK;
                end
                S_FILL: begin
                    DATA_VALID = 1'b1;
                    Data_Cache = word_q;
                end
                default: begin
                end
            endcase
        end else begin
        end
    end

    assign CNT_HIT  = cnt_hit_q;
    assign CNT_MISS = cnt_miss_q;

endmodule

// File: tb/tb_cache_set_assoc_multiword.sv
// Directed bench for cache_set_assoc_multiword (SETS=4, WAYS=2, 2 words/block); a CNT_W=4 twin shares the stimulus.
module tb_cache_set_assoc_multiword;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        mm_valid = 1'b0;
    logic [63:0] mm_data = 64'd0;

    logic        hit, dv, stall, mm_req;
    logic [31:0] data, mm_addr;
    logic [19:0] cnt_hit, cnt_miss;
    logic        hit4, dv4, stall4, mm_req4;
    logic [31:0] data4, mm_addr4;
    logic [3:0]  cnt_hit4, cnt_miss4;

    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_set_assoc_multiword #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_BLOCK(2), .SETS(4), .WAYS(2), .CNT_W(20)) u_dut (
        .CLK(clk), .RESET(rst_n), .REQ(req),
`ifdef CACHE_FLUSH_EN
        .FLUSH(flush),
`endif
        .PC(pc), .HIT(hit), .DATA_VALID(dv), .Data_Cache(data), .STALL(stall),
        .MM_REQ(mm_req), .MM_ADDR(mm_addr), .MM_VALID(mm_valid), .MM_DATA(mm_data),
        .CNT_HIT(cnt_hit), .CNT_MISS(cnt_miss)
    );

    cache_set_assoc_multiword #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_BLOCK(2), .SETS(4), .WAYS(2), .CNT_W(4)) u_dut4 (
        .CLK(clk), .RESET(rst_n), .REQ(req),
`ifdef CACHE_FLUSH_EN
        .FLUSH(flush),
`endif
        .PC(pc), .HIT(hit4), .DATA_VALID(dv4), .Data_Cache(data4), .STALL(stall4),
        .MM_REQ(mm_req4), .MM_ADDR(mm_addr4), .MM_VALID(mm_valid), .MM_DATA(mm_data),
        .CNT_HIT(cnt_hit4), .CNT_MISS(cnt_miss4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; mm_valid = 1'b0; flush = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_hit(input logic [31:0] a);
        pc = a; req = 1'b1;
        #1;
        chk("hit_flag", hit, 1);
        chk("hit_dv", dv, 1);
        chk("hit_data", data, a);
        chk("hit_stall", stall, 0);
        tick();
        req = 1'b0;
    endtask

    // Miss flow: memory answers 3 cycles after MM_REQ with word data equal to its byte address.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] blk, input bit flush_mid);
        pc = a; req = 1'b1;
        #1;
        chk("miss_stall", stall, 1);
        chk("miss_hit", hit, 0);
        tick();
        chk("mm_req", mm_req, 1);
        chk("mm_addr", mm_addr, blk);
        if (flush_mid) flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        mm_valid = 1'b1; mm_data = {blk + 32'd4, blk};
        tick();
        mm_valid = 1'b0;
        chk("fill_dv", dv, 1);
        chk("fill_data", data, a);
        chk("fill_stall", stall, 0);
        chk("fill_mm_req", mm_req, 0);
        req = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state, with REQ already high to show outputs stay quiet.
        req = 1'b1; pc = 32'd0;
        #2;
        chk("rst_hit", hit, 0);
        chk("rst_dv", dv, 0);
        chk("rst_data", data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mm_req", mm_req, 0);
        chk("rst_mm_addr", mm_addr, 0);
        chk("rst_cnt_hit", cnt_hit, 0);
        chk("rst_cnt_miss", cnt_miss, 0);
        do_reset();

        // Cold miss, neighbour-word hit, next-block miss.
        do_miss(32'd0, 32'd0, 1'b0);
        chk("cold_cnt_miss", cnt_miss, 1);
        chk("cold_cnt_hit", cnt_hit, 0);
        do_hit(32'd4);
        chk("cnt_hit_after_4", cnt_hit, 1);
        do_miss(32'd8, 32'd8, 1'b0);
        chk("cnt_miss_after_8", cnt_miss, 2);
        #1;
        chk("idle_noreq_hit", hit, 0);
        chk("idle_noreq_stall", stall, 0);

        // LRU within set 0: 64 must evict the 32 line, not the recently used 0 line.
        do_reset();
        do_miss(32'd0, 32'd0, 1'b0);
        do_miss(32'd32, 32'd32, 1'b0);
        do_hit(32'd0);
        do_miss(32'd64, 32'd64, 1'b0);
        do_hit(32'd0);
        do_miss(32'd32, 32'd32, 1'b0);
        chk("lru_cnt_miss", cnt_miss, 4);
        chk("lru_cnt_hit", cnt_hit, 2);

        // Reset in the middle of a refill, then a stray late MM_VALID.
        do_reset();
        pc = 32'd0; req = 1'b1;
        tick();
        chk("mid_mm_req_before", mm_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mm_req", mm_req, 0);
        chk("mid_rst_stall", stall, 0);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        mm_valid = 1'b1; mm_data = {32'd4, 32'd0};
        tick();
        mm_valid = 1'b0;
        chk("late_valid_dv", dv, 0);
        chk("late_valid_cnt_miss", cnt_miss, 0);
        do_miss(32'd0, 32'd0, 1'b0);
        chk("remiss_cnt_miss", cnt_miss, 1);

        // Counter saturation on the CNT_W=4 twin.
        do_reset();
        do_miss(32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) do_hit(32'd0);
        chk("sat_cnt_hit4", cnt_hit4, 15);
        chk("sat_cnt_miss4", cnt_miss4, 1);
        chk("wide_cnt_hit", cnt_hit, 20);

`ifdef CACHE_FLUSH_EN
        // Flush in IDLE, then flush arriving during a refill.
        do_reset();
        do_miss(32'd0, 32'd0, 1'b0);
        do_miss(32'd32, 32'd32, 1'b0);
        pc = 32'd0; req = 1'b1; flush = 1'b1;
        #1;
        chk("flush_hit_blocked", hit, 0);
        tick();
        flush = 1'b0; req = 1'b0;
        chk("flush_no_count", cnt_hit, 0);
        do_miss(32'd0, 32'd0, 1'b0);
        do_miss(32'd32, 32'd32, 1'b0);
        do_miss(32'd8, 32'd8, 1'b1);
        do_miss(32'd8, 32'd8, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
